// File: rtl/rw_memory_bus.sv
// Single-port data memory with request/ready handshake, wait states, registered read data and
// misalignment errors. Define RW_MEMORY_BYTE_ENABLE_EN to make i_be gate the write lanes.
module rw_memory_bus #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_req,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_ready,
    output logic                    o_error,
    output logic                    o_busy
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int IDXW  = ADDR_WIDTH - OFS;
    localparam int DEPTH = 2 ** IDXW;
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [BYTES-1:0]        be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    accept;
    logic                    commit;
    logic                    use_live;
    logic                    c_we;
    logic [ADDR_WIDTH-1:0]   c_addr;
    logic [BYTES-1:0]        c_be;
    logic [DATA_WIDTH-1:0]   c_wdata;
    logic [IDXW-1:0]         c_idx;
    logic                    c_mis;
    logic [BYTES-1:0]        lane_en;
    logic                    mem_we;

    assign accept = i_req && (state_q != ST_WAIT);

    // With no wait states the commit edge is also the accept edge, so the live inputs are used.
    assign use_live = (state_q != ST_WAIT);
    assign c_we     = use_live ? i_we    : we_q;
    assign c_addr   = use_live ? i_addr  : addr_q;
    assign c_be     = use_live ? i_be    : be_q;
    assign c_wdata  = use_live ? i_wdata : wdata_q;
    assign c_idx    = c_addr[ADDR_WIDTH-1:OFS];

    if (OFS == 0) begin : g_no_offset
        assign c_mis = 1'b0;
    end else begin : g_offset
        assign c_mis = |c_addr[OFS-1:0];
    end

`ifdef RW_MEMORY_BYTE_ENABLE_EN
    assign lane_en = c_be;
`else
    logic unused_be;
    assign unused_be = ^c_be;
    assign lane_en   = '1;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = ST_DONE;
                        commit  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= i_we;
                addr_q  <= i_addr;
                be_q    <= i_be;
                wdata_q <= i_wdata;
            end
            if (commit) begin
                err_q <= c_mis;
                if (!c_we && !c_mis) begin
                    rdata_q <= mem[c_idx];
                end
            end
        end
    end

    // The array has no reset, so a held reset must explicitly block writes.
    assign mem_we = commit && c_we && !c_mis && i_reset;

    always_ff @(posedge i_clock) begin
        if (mem_we) begin
            for (int n = 0; n < BYTES; n++) begin
                if (lane_en[n]) begin
                    mem[c_idx][8*n +: 8] <= c_wdata[8*n +: 8];
                end
            end
        end
    end

    assign o_rdata = rdata_q;
    assign o_ready = (state_q == ST_DONE);
    assign o_error = (state_q == ST_DONE) && err_q;
    assign o_busy  = (state_q == ST_WAIT);

endmodule
